// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decodes opcode/funct into an ALU control code, registers
// operands for the external ALU, runs DIV/REM on an internal restoring divider, holds the result.
module alu_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] src_a,
  output logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] alu_out,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_out,
  output logic            illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_AND = 4'b0001, OP_SUB = 4'b0010,
                         OP_SLT = 4'b0011, OP_DIV = 4'b0100, OP_REM = 4'b0101,
                         OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SRA = 4'b1000,
                         OP_SGE = 4'b1001;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q, quo_q;

  logic [3:0]       dec_ctrl;
  logic             dec_imm, dec_bad, dec_div;
  logic [XLEN:0]    shifted, diff;
  logic             q_bit;
  logic [XLEN-1:0]  rem_next, quo_next, div_res;

  assign ready_in = (state == IDLE) && !reset;

  always_comb begin
    dec_ctrl = OP_ADD;
    dec_imm  = 1'b0;
    dec_bad  = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000001) begin
          case (funct3)
            3'b100, 3'b101: dec_ctrl = OP_DIV;
            3'b110, 3'b111: dec_ctrl = OP_REM;
            default:        dec_bad  = 1'b1;
          endcase
        end else if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:         dec_ctrl = funct7[5] ? OP_SUB : OP_ADD;
            3'b111:         dec_ctrl = OP_AND;
            3'b001:         dec_ctrl = OP_SLL;
            3'b101:         dec_ctrl = funct7[5] ? OP_SRA : OP_SRL;
            3'b010, 3'b011: dec_ctrl = OP_SLT;
            default:        dec_bad  = 1'b1;
          endcase
        end else begin
          dec_bad = 1'b1;
        end
      end
      7'b0010011: begin
        dec_imm = 1'b1;
        case (funct3)
          3'b000:         dec_ctrl = OP_ADD;
          3'b111:         dec_ctrl = OP_AND;
          3'b001:         dec_ctrl = OP_SLL;
          3'b101:         dec_ctrl = imm[10] ? OP_SRA : OP_SRL;
          3'b010, 3'b011: dec_ctrl = OP_SLT;
          default:        dec_bad  = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: dec_imm = 1'b1;
      7'b1100011: begin
        case (funct3)
          3'b000, 3'b001: dec_ctrl = OP_SUB;
          3'b100, 3'b110: dec_ctrl = OP_SLT;
          3'b101, 3'b111: dec_ctrl = OP_SGE;
          default:        dec_bad  = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
    dec_div = !dec_bad && (dec_ctrl == OP_DIV || dec_ctrl == OP_REM);
  end

  // One restoring step: a clear borrow bit means the shifted remainder covers the divisor.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, src_b};
    q_bit    = !diff[XLEN];
    rem_next = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_next = {quo_q[XLEN-2:0], q_bit};
    if (src_b == '0) div_res = (alu_control == OP_DIV) ? '1 : src_a;
    else             div_res = (alu_control == OP_DIV) ? quo_next : rem_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      alu_control  <= OP_ADD;
      src_a        <= '0;
      src_b        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      zero_out     <= 1'b0;
      illegal      <= 1'b0;
      cnt          <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          alu_control <= dec_ctrl;
          src_a       <= rs1_val;
          src_b       <= dec_imm ? imm : rs2_val;
          illegal     <= dec_bad;
          cnt         <= '0;
          rem_q       <= '0;
          quo_q       <= rs1_val;
          if (dec_bad) begin
            result       <= '0;
            zero_out     <= 1'b1;
            result_valid <= 1'b1;
            state        <= DONE;
          end else if (dec_div) begin
            state <= DIV;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          result       <= alu_out;
          zero_out     <= (alu_out == '0);
          result_valid <= 1'b1;
          state        <= DONE;
        end
        // A zero divisor short-circuits on the first cycle instead of iterating.
        DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt   <= cnt + 1'b1;
          if (src_b == '0 || cnt == LAST_ITER) begin
            result       <= div_res;
            zero_out     <= (div_res == '0);
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: if (result_ready) begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a small behavioural ALU closes the loop on alu_out.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_in;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [3:0]  alu_control;
  logic [31:0] src_a, src_b, alu_out, result;
  logic        result_valid, result_ready, zero_out, illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b), .alu_out(alu_out),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .zero_out(zero_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference ALU for the non-divide codes.
  always_comb begin
    alu_out = '0;
    case (alu_control)
      4'b0000: alu_out = src_a + src_b;
      4'b0001: alu_out = src_a & src_b;
      4'b0010: alu_out = src_a - src_b;
      4'b0011: alu_out = {31'd0, src_a < src_b};
      4'b0110: alu_out = src_a << src_b[4:0];
      4'b0111: alu_out = src_a >> src_b[4:0];
      4'b1000: alu_out = $signed(src_a) >>> src_b[4:0];
      4'b1001: alu_out = {31'd0, src_a >= src_b};
      default: alu_out = '0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic chk_ctrl, input logic [3:0] exp_ctrl,
                       input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
    int n = 0;
    applyStimulus(op, f3, f7, a, b, im);
    checkOutput({tag, "_busy"}, {31'd0, ready_in}, 32'd0);
    if (chk_ctrl) checkOutput({tag, "_ctrl"}, {28'd0, alu_control}, {28'd0, exp_ctrl});
    while (!result_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_lat"}, n, exp_lat);
    checkOutput({tag, "_res"}, result, exp_res);
    checkOutput({tag, "_zero"}, {31'd0, zero_out}, {31'd0, exp_res == 32'd0});
    checkOutput({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
    @(posedge clk); #1;
    checkOutput({tag, "_idle"}, {31'd0, ready_in, result_valid}, 32'd2);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; result_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; rs1_val = '0; rs2_val = '0; imm = '0;
    #12;
    checkOutput("rst_ready", {31'd0, ready_in}, 32'd0);
    checkOutput("rst_flags", {28'd0, result_valid, zero_out, illegal, 1'b0}, 32'd0);
    checkOutput("rst_ctrl", {28'd0, alu_control}, 32'd0);
    checkOutput("rst_res", result | src_a | src_b, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("rst_rel_ready", {31'd0, ready_in}, 32'd1);

    runOp("add",   7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7, 32'd0, 1'b1, 4'b0000, 32'd12, 1'b0, 1);
    runOp("beq",   7'b1100011, 3'b000, 7'b0000000, 32'h1234, 32'h1234, 32'd0, 1'b1, 4'b0010, 32'd0, 1'b0, 1);
    runOp("sub",   7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3, 32'd0, 1'b1, 4'b0010, 32'd7, 1'b0, 1);
    runOp("andi",  7'b0010011, 3'b111, 7'b0000000, 32'hF0F0, 32'd0, 32'h0FF0, 1'b1, 4'b0001, 32'h00F0, 1'b0, 1);
    runOp("srai",  7'b0010011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'h402, 1'b1, 4'b1000, 32'hE000_0000, 1'b0, 1);
    runOp("sltu",  7'b0110011, 3'b011, 7'b0000000, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b1, 4'b0011, 32'd1, 1'b0, 1);
    runOp("bgeu",  7'b1100011, 3'b111, 7'b0000000, 32'd5, 32'd5, 32'd0, 1'b1, 4'b1001, 32'd1, 1'b0, 1);
    runOp("load",  7'b0000011, 3'b010, 7'b0000000, 32'h100, 32'd0, 32'hFFFF_FFFC, 1'b1, 4'b0000, 32'hFC, 1'b0, 1);
    runOp("divu",  7'b0110011, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd0, 1'b1, 4'b0100, 32'd14, 1'b0, 32);
    runOp("remu",  7'b0110011, 3'b111, 7'b0000001, 32'd100, 32'd7, 32'd0, 1'b1, 4'b0101, 32'd2, 1'b0, 32);
    runOp("divbig",7'b0110011, 3'b101, 7'b0000001, 32'hFFFF_FFFF, 32'h10, 32'd0, 1'b1, 4'b0100, 32'h0FFF_FFFF, 1'b0, 32);
    runOp("rembig",7'b0110011, 3'b111, 7'b0000001, 32'hFFFF_FFFF, 32'h10, 32'd0, 1'b1, 4'b0101, 32'hF, 1'b0, 32);
    runOp("div0",  7'b0110011, 3'b101, 7'b0000001, 32'd9, 32'd0, 32'd0, 1'b1, 4'b0100, 32'hFFFF_FFFF, 1'b0, 1);
    runOp("rem0",  7'b0110011, 3'b111, 7'b0000001, 32'd9, 32'd0, 32'd0, 1'b1, 4'b0101, 32'd9, 1'b0, 1);
    runOp("ill_r", 7'b0110011, 3'b100, 7'b0000000, 32'd4, 32'd4, 32'd0, 1'b0, 4'b0000, 32'd0, 1'b1, 0);
    runOp("ill_clr", 7'b0110011, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd0, 1'b1, 4'b0000, 32'd7, 1'b0, 1);

    // Illegal opcode with a stalled consumer: outputs must hold.
    result_ready = 1'b0;
    applyStimulus(7'b0110111, 3'b000, 7'b0000000, 32'd1, 32'd2, 32'd3);
    checkOutput("lui_valid", {31'd0, result_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("lui_hold", {29'd0, result_valid, illegal, ready_in}, 32'd6);
      checkOutput("lui_res", result, 32'd0);
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("lui_release", {31'd0, ready_in, result_valid}, 32'd2);

    // Reset during divider iteration 10 must abort without a result.
    applyStimulus(7'b0110011, 3'b101, 7'b0000001, 32'd100, 32'd7, 32'd0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort_ready", {31'd0, ready_in}, 32'd0);
    checkOutput("abort_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("abort_ops", src_a | src_b | result, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_idle", {31'd0, ready_in}, 32'd1);
    @(posedge clk); #1;
    runOp("add_after", 7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 1'b1, 4'b0000, 32'd2, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
